// File: rtl/ioctl_download_packer.sv
// HPS ioctl download front end: packs the 16-bit ioctl stream into OUT_BYTES-wide words,
// applies per-channel base/byte order and queues the words in a small output FIFO.
module ioctl_download_packer #(
  parameter int unsigned OUT_BYTES  = 4,
  parameter int unsigned CH_COUNT   = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 27
) (
  input  logic                                           clk1x,
  input  logic                                           reset,
  input  logic                                           ioctl_download,
  input  logic [7:0]                                     ioctl_index,
  input  logic [ADDR_W-1:0]                              ioctl_addr,
  input  logic [15:0]                                    ioctl_dout,
  input  logic                                           ioctl_wr,
  output logic                                           ioctl_wait,
  input  logic [CH_COUNT*ADDR_W-1:0]                     ch_base,
  input  logic [CH_COUNT-1:0]                            ch_swap,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic [(CH_COUNT > 1 ? $clog2(CH_COUNT) : 1)-1:0] out_ch,
  output logic [ADDR_W-1:0]                              out_addr,
  output logic [OUT_BYTES*8-1:0]                         out_data,
  output logic [OUT_BYTES-1:0]                           out_be,
  output logic [CH_COUNT-1:0]                            dl_active,
  output logic [CH_COUNT-1:0]                            dl_done,
  output logic                                           overflow_err
);

  localparam int unsigned CH_W   = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1;
  localparam int unsigned LANES  = OUT_BYTES / 2;
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned OB_W   = $clog2(OUT_BYTES);
  localparam int unsigned DW     = OUT_BYTES * 8;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam logic [LANE_W-1:0] LAST = LANE_W'(LANES - 1);

  typedef struct packed {
    logic [CH_W-1:0]      ch;
    logic [ADDR_W-1:0]    addr;
    logic [DW-1:0]        data;
    logic [OUT_BYTES-1:0] be;
  } word_t;

  word_t              mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count, count_n;
  logic               push_q, push_n, push_acc, pop, fifo_full;
  word_t              push_word_q, push_word_n;

  logic               pk_open, pk_open_n, pk_pend, pk_pend_n;
  logic [CH_W-1:0]    pk_ch, pk_ch_n;
  logic [ADDR_W-1:0]  pk_tag, pk_tag_n;
  logic [DW-1:0]      pk_data, pk_data_n;
  logic [OUT_BYTES-1:0] pk_be, pk_be_n;

  logic               done_pend, done_fire;
  logic [CH_W-1:0]    done_ch;

  logic [5:0]         idx;
  logic               sel_ok, wr_ok, ovf_wr, ovf_push, wr_swap, end_evt, wait_n;
  logic [CH_W-1:0]    sel_ch, end_ch;
  logic [CH_COUNT-1:0] act_vec;
  logic [LANE_W-1:0]  lane, slot;
  logic [ADDR_W-1:0]  tag, base_pk, base_sel;
  logic [15:0]        hw;

  // Index decode, lane placement and channel lookups
  always_comb begin
    idx      = ioctl_index[5:0];
    sel_ok   = ioctl_download && (32'(idx) < CH_COUNT);
    sel_ch   = CH_W'(idx);
    wr_swap  = ch_swap[sel_ch];
    lane     = (LANES > 1) ? LANE_W'(ioctl_addr[ADDR_W-1:1]) : '0;
    slot     = wr_swap ? LAST - lane : lane;
    tag      = {ioctl_addr[ADDR_W-1:OB_W], OB_W'(0)};
    hw       = wr_swap ? {ioctl_dout[7:0], ioctl_dout[15:8]} : ioctl_dout;
    act_vec  = '0;
    base_pk  = '0;
    base_sel = '0;
    end_evt  = 1'b0;
    end_ch   = '0;
    for (int n = 0; n < int'(CH_COUNT); n++) begin
      act_vec[n] = ioctl_download && (idx == 6'(n));
      if (pk_ch == CH_W'(n)) base_pk = ch_base[n*ADDR_W +: ADDR_W];
      if (sel_ch == CH_W'(n)) base_sel = ch_base[n*ADDR_W +: ADDR_W];
      if (dl_active[n] && !act_vec[n]) begin
        end_evt = 1'b1;
        end_ch  = CH_W'(n);
      end
    end
  end

  // FIFO occupancy; a pop frees a slot for a same-cycle push
  always_comb begin
    pop       = out_valid && out_ready;
    fifo_full = (count == CNT_W'(FIFO_DEPTH));
    push_acc  = push_q && (!fifo_full || pop);
    ovf_push  = push_q && fifo_full && !pop;
    ovf_wr    = ioctl_wr && sel_ok && fifo_full;
    wr_ok     = ioctl_wr && sel_ok && !fifo_full;
    count_n   = count;
    if (push_acc && !pop) count_n = count + CNT_W'(1);
    else if (!push_acc && pop) count_n = count - CNT_W'(1);
  end

  // Pack buffer update; at most one push per cycle, a second complete word is deferred
  always_comb begin
    pk_open_n   = pk_open;
    pk_pend_n   = 1'b0;
    pk_ch_n     = pk_ch;
    pk_tag_n    = pk_tag;
    pk_data_n   = pk_data;
    pk_be_n     = pk_be;
    push_n      = 1'b0;
    push_word_n = '0;
    if (pk_pend) begin
      push_n           = 1'b1;
      push_word_n.ch   = pk_ch;
      push_word_n.addr = base_pk + pk_tag;
      push_word_n.data = pk_data;
      push_word_n.be   = pk_be;
      pk_open_n        = 1'b0;
    end
    if (wr_ok) begin
      if (pk_open_n && (tag != pk_tag || sel_ch != pk_ch)) begin
        push_n           = 1'b1;
        push_word_n.ch   = pk_ch;
        push_word_n.addr = base_pk + pk_tag;
        push_word_n.data = pk_data;
        push_word_n.be   = pk_be;
        pk_open_n        = 1'b0;
      end
      if (!pk_open_n) begin
        pk_ch_n   = sel_ch;
        pk_tag_n  = tag;
        pk_data_n = '0;
        pk_be_n   = '0;
      end
      for (int i = 0; i < int'(LANES); i++) begin
        if (slot == LANE_W'(i)) begin
          pk_data_n[16*i +: 16] = hw;
          pk_be_n[2*i +: 2]     = 2'b11;
        end
      end
      pk_open_n = 1'b1;
      if (lane == LAST) begin
        if (push_n) begin
          pk_pend_n = 1'b1;
        end else begin
          push_n           = 1'b1;
          push_word_n.ch   = sel_ch;
          push_word_n.addr = base_sel + tag;
          push_word_n.data = pk_data_n;
          push_word_n.be   = pk_be_n;
          pk_open_n        = 1'b0;
        end
      end
    end else if (end_evt && pk_open_n && pk_ch == end_ch) begin
      push_n           = 1'b1;
      push_word_n.ch   = pk_ch;
      push_word_n.addr = base_pk + pk_tag;
      push_word_n.data = pk_data;
      push_word_n.be   = pk_be;
      pk_open_n        = 1'b0;
    end
    done_fire = done_pend && !push_q && !pk_pend && (count == '0);
    wait_n    = sel_ok && ((count_n >= CNT_W'(FIFO_DEPTH - 1)) || pk_pend_n);
  end

  always_ff @(posedge clk1x) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      push_q       <= 1'b0;
      push_word_q  <= '0;
      pk_open      <= 1'b0;
      pk_pend      <= 1'b0;
      pk_ch        <= '0;
      pk_tag       <= '0;
      pk_data      <= '0;
      pk_be        <= '0;
      done_pend    <= 1'b0;
      done_ch      <= '0;
      dl_active    <= '0;
      dl_done      <= '0;
      ioctl_wait   <= 1'b0;
      out_valid    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      push_q       <= push_n;
      push_word_q  <= push_word_n;
      pk_open      <= pk_open_n;
      pk_pend      <= pk_pend_n;
      pk_ch        <= pk_ch_n;
      pk_tag       <= pk_tag_n;
      pk_data      <= pk_data_n;
      pk_be        <= pk_be_n;
      count        <= count_n;
      out_valid    <= (count_n != '0);
      dl_active    <= act_vec;
      ioctl_wait   <= wait_n;
      overflow_err <= overflow_err || ovf_wr || ovf_push;
      dl_done      <= done_fire ? (CH_COUNT'(1) << done_ch) : '0;
      if (push_acc) begin
        mem[wr_ptr] <= push_word_q;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (end_evt) begin
        done_pend <= 1'b1;
        done_ch   <= end_ch;
      end else if (done_fire) begin
        done_pend <= 1'b0;
      end
    end
  end

  assign out_ch   = mem[rd_ptr].ch;
  assign out_addr = mem[rd_ptr].addr;
  assign out_data = mem[rd_ptr].data;
  assign out_be   = mem[rd_ptr].be;

endmodule

// File: tb/tb_ioctl_download_packer.sv
// Directed bench for ioctl_download_packer (OUT_BYTES=4, CH_COUNT=2, FIFO_DEPTH=4).
module tb_ioctl_download_packer;

  localparam int unsigned ADDR_W = 27;

  logic              clk1x = 1'b0;
  logic              reset;
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [15:0]       ioctl_dout;
  logic              ioctl_wr;
  logic              ioctl_wait;
  logic [2*ADDR_W-1:0] ch_base;
  logic [1:0]        ch_swap;
  logic              out_valid;
  logic              out_ready;
  logic [0:0]        out_ch;
  logic [ADDR_W-1:0] out_addr;
  logic [31:0]       out_data;
  logic [3:0]        out_be;
  logic [1:0]        dl_active;
  logic [1:0]        dl_done;
  logic              overflow_err;

  int checks = 0;
  int errors = 0;

  always #5 clk1x = ~clk1x;

  ioctl_download_packer #(
    .OUT_BYTES(4), .CH_COUNT(2), .FIFO_DEPTH(4), .ADDR_W(ADDR_W)
  ) dut (
    .clk1x(clk1x), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr), .ioctl_wait(ioctl_wait),
    .ch_base(ch_base), .ch_swap(ch_swap), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_addr(out_addr), .out_data(out_data), .out_be(out_be),
    .dl_active(dl_active), .dl_done(dl_done), .overflow_err(overflow_err)
  );

  task automatic tick();
    @(posedge clk1x);
    #1;
  endtask

  task automatic hw_write(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; ioctl_download = 1'b0; ioctl_index = '0; ioctl_addr = '0;
    ioctl_dout = '0; ioctl_wr = 1'b0; out_ready = 1'b0;
    ch_base = {27'h0100000, 27'h0002000};
    ch_swap = 2'b01;
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL reset_wait got %b want 0", ioctl_wait); end
    checks++; if (dl_active !== 2'b00 || dl_done !== 2'b00) begin errors++; $display("FAIL reset_dl got %b/%b want 00/00", dl_active, dl_done); end
    checks++; if (overflow_err !== 1'b0 || out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %b/%h want 0/0", overflow_err, out_data); end
  endtask

  task automatic test_pack_ch1();
    ioctl_index = 8'd1; ioctl_download = 1'b1;
    tick();
    checks++; if (dl_active !== 2'b10) begin errors++; $display("FAIL pack_active got %b want 10", dl_active); end
    hw_write(27'h0, 16'h1111);
    hw_write(27'h2, 16'h2222);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pack_latency got %b want 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pack_valid got %b want 1", out_valid); end
    checks++; if (out_addr !== 27'h0100000 || out_ch !== 1'b1) begin errors++; $display("FAIL pack_addr got %h/%b want 0100000/1", out_addr, out_ch); end
    checks++; if (out_data !== 32'h22221111 || out_be !== 4'hF) begin errors++; $display("FAIL pack_data got %h/%h want 22221111/f", out_data, out_be); end
    pop_one();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pack_pop got %b want 0", out_valid); end
    ioctl_download = 1'b0;
    tick();
    checks++; if (dl_active !== 2'b00 || dl_done !== 2'b00) begin errors++; $display("FAIL pack_end got %b/%b want 00/00", dl_active, dl_done); end
    tick();
    checks++; if (dl_done !== 2'b10) begin errors++; $display("FAIL pack_done got %b want 10", dl_done); end
    tick();
    checks++; if (dl_done !== 2'b00) begin errors++; $display("FAIL pack_done_pulse got %b want 00", dl_done); end
  endtask

  task automatic test_swap_ch0();
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    tick();
    hw_write(27'h0, 16'h3780);
    hw_write(27'h2, 16'h1240);
    tick();
    checks++; if (out_data !== 32'h80374012 || out_be !== 4'hF) begin errors++; $display("FAIL swap_data got %h/%h want 80374012/f", out_data, out_be); end
    checks++; if (out_ch !== 1'b0 || out_addr !== 27'h0002000) begin errors++; $display("FAIL swap_addr got %b/%h want 0/0002000", out_ch, out_addr); end
    pop_one();
    end_dl();
  endtask

  task automatic test_odd_length();
    ioctl_index = 8'd1; ioctl_download = 1'b1;
    tick();
    hw_write(27'h0, 16'hAAAA);
    ioctl_download = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h0000AAAA || out_be !== 4'h3) begin errors++; $display("FAIL odd_word got %b/%h/%h want 1/0000aaaa/3", out_valid, out_data, out_be); end
    checks++; if (dl_done !== 2'b00) begin errors++; $display("FAIL odd_early_done got %b want 00", dl_done); end
    pop_one();
    checks++; if (out_valid !== 1'b0 || dl_done !== 2'b00) begin errors++; $display("FAIL odd_pop got %b/%b want 0/00", out_valid, dl_done); end
    tick();
    checks++; if (dl_done !== 2'b10) begin errors++; $display("FAIL odd_done got %b want 10", dl_done); end
    tick();
    checks++; if (dl_done !== 2'b00) begin errors++; $display("FAIL odd_done_pulse got %b want 00", dl_done); end
  endtask

  task automatic test_back_to_back();
    int i = 0;
    int nw = 0;
    logic wrote;
    logic [31:0] exp_data;
    ioctl_index = 8'd1; ioctl_download = 1'b1; out_ready = 1'b0;
    tick();
    for (int c = 0; c < 20; c++) begin
      wrote = 1'b0;
      if (i < 8 && !ioctl_wait) begin
        ioctl_addr = ADDR_W'(2 * i); ioctl_dout = 16'(16'h1000 + i); ioctl_wr = 1'b1; wrote = 1'b1;
      end else ioctl_wr = 1'b0;
      tick();
      if (wrote) i++;
    end
    ioctl_wr = 1'b0;
    checks++; if (ioctl_wait !== 1'b1 || i != 7) begin errors++; $display("FAIL bp_wait got %b/%0d want 1/7", ioctl_wait, i); end
    out_ready = 1'b1;
    for (int c = 0; c < 100 && nw < 4; c++) begin
      if (out_valid && out_ready) begin
        exp_data = {16'(16'h1000 + 2 * nw + 1), 16'(16'h1000 + 2 * nw)};
        checks++;
        if (out_data !== exp_data || out_addr !== ADDR_W'(27'h0100000 + 4 * nw) || out_be !== 4'hF) begin
          errors++; $display("FAIL bp_word%0d got %h@%h want %h@%h", nw, out_data, out_addr, exp_data, 27'h0100000 + 4 * nw);
        end
        nw++;
      end
      wrote = 1'b0;
      if (i < 8 && !ioctl_wait) begin
        ioctl_addr = ADDR_W'(2 * i); ioctl_dout = 16'(16'h1000 + i); ioctl_wr = 1'b1; wrote = 1'b1;
      end else ioctl_wr = 1'b0;
      tick();
      if (wrote) i++;
    end
    ioctl_wr = 1'b0; out_ready = 1'b0;
    checks++; if (nw != 4 || i != 8 || overflow_err !== 1'b0) begin errors++; $display("FAIL bp_drain got %0d/%0d/%b want 4/8/0", nw, i, overflow_err); end
    end_dl();
  endtask

  task automatic test_skip();
    ioctl_index = 8'd1; ioctl_download = 1'b1; out_ready = 1'b0;
    tick();
    hw_write(27'h0, 16'h1111);
    hw_write(27'h8, 16'h5555);
    hw_write(27'hA, 16'h6666);
    tick();
    checks++; if (out_addr !== 27'h0100000 || out_data !== 32'h00001111 || out_be !== 4'h3) begin errors++; $display("FAIL skip_partial got %h/%h/%h want 0100000/00001111/3", out_addr, out_data, out_be); end
    pop_one();
    checks++; if (out_addr !== 27'h0100008 || out_data !== 32'h66665555 || out_be !== 4'hF) begin errors++; $display("FAIL skip_next got %h/%h/%h want 0100008/66665555/f", out_addr, out_data, out_be); end
    pop_one();
    hw_write(27'h10, 16'h7777);
    hw_write(27'h16, 16'h8888);
    checks++; if (ioctl_wait !== 1'b1) begin errors++; $display("FAIL split_wait got %b want 1", ioctl_wait); end
    tick();
    checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL split_wait_drop got %b want 0", ioctl_wait); end
    tick();
    checks++; if (out_addr !== 27'h0100010 || out_data !== 32'h00007777 || out_be !== 4'h3) begin errors++; $display("FAIL split_old got %h/%h/%h want 0100010/00007777/3", out_addr, out_data, out_be); end
    pop_one();
    checks++; if (out_valid !== 1'b1 || out_addr !== 27'h0100014 || out_data !== 32'h88880000 || out_be !== 4'hC) begin errors++; $display("FAIL split_new got %b/%h/%h/%h want 1/0100014/88880000/c", out_valid, out_addr, out_data, out_be); end
    pop_one();
    end_dl();
  endtask

  task automatic test_bad_index();
    ioctl_index = 8'd9; ioctl_download = 1'b1;
    tick();
    hw_write(27'h0, 16'h1111);
    hw_write(27'h2, 16'h2222);
    tick(); tick(); tick();
    checks++; if (out_valid !== 1'b0 || ioctl_wait !== 1'b0 || dl_active !== 2'b00) begin errors++; $display("FAIL bad_index got %b/%b/%b want 0/0/00", out_valid, ioctl_wait, dl_active); end
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    ioctl_index = 8'd1; ioctl_download = 1'b1; out_ready = 1'b0;
    tick();
    for (int k = 0; k < 9; k++) hw_write(ADDR_W'(2 * k), 16'(k));
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", overflow_err); end
    hw_write(27'h12, 16'h0009);
    tick();
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow_err); end
    reset = 1'b1; ioctl_download = 1'b0;
    tick();
    reset = 1'b0;
    checks++; if (overflow_err !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b/%b want 0/0", overflow_err, out_valid); end
  endtask

  task automatic test_reset_mid();
    ioctl_index = 8'd1; ioctl_download = 1'b1; out_ready = 1'b0;
    tick();
    hw_write(27'h0, 16'hA0A0);
    hw_write(27'h2, 16'hA1A1);
    hw_write(27'h4, 16'hA2A2);
    hw_write(27'h6, 16'hA3A3);
    tick();
    checks++; if (out_valid !== 1'b1 || dl_active !== 2'b10) begin errors++; $display("FAIL mid_queued got %b/%b want 1/10", out_valid, dl_active); end
    reset = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || ioctl_wait !== 1'b0 || dl_active !== 2'b00) begin errors++; $display("FAIL mid_reset got %b/%b/%b want 0/0/00", out_valid, ioctl_wait, dl_active); end
    ioctl_download = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_pack_ch1();
    test_swap_ch0();
    test_odd_length();
    test_back_to_back();
    test_skip();
    test_bad_index();
    test_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
